// File: rtl/fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit_if : fetch-to-decode instruction handshake bundle         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface fetch_unit_if #(
  parameter int ADDR_W = 30
) ();
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic [ADDR_W-1:0] pc_plus1;

  modport master (
    output instr_valid,
    output instr,
    output instr_pc,
    output pc_plus1,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    input  instr_pc,
    input  pc_plus1,
    output instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit : fetch PC, writable instruction memory, fetch queue      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_unit #(
  parameter int                ADDR_W   = 30,
  parameter int                DEPTH    = 32,
  parameter int                QDEPTH   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  wire                clk,
  input  wire                rst,
  input  wire                imem_we_i,
  input  wire [ADDR_W-1:0]   imem_waddr_i,
  input  wire [31:0]         imem_wdata_i,
  input  wire                branch_i,
  input  wire                zero_i,
  input  wire                jump_i,
  input  wire [ADDR_W-1:0]   br_pc_i,
  input  wire [15:0]         br_imm_i,
  input  wire [25:0]         jump_idx_i,
  fetch_unit_if.master       dec_if
);

  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                CNT_W     = $clog2(QDEPTH + 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]  QFULL     = CNT_W'(QDEPTH);

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  logic [31:0]       mem_q [DEPTH];
  entry_t            ent_q [QDEPTH];
  entry_t            ent_d [QDEPTH];
  logic [CNT_W-1:0]  count_q, count_d, wr_idx;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [ADDR_W-1:0] pc_inc, br_tgt, jmp_tgt, tgt;
  logic [31:0]       rdata;
  logic              pop, push, redirect, rd_hit, wr_hit, head_valid;

  assign rd_hit = {1'b0, fpc_q} < DEPTH_EXT;
  assign wr_hit = {1'b0, imem_waddr_i} < DEPTH_EXT;
  assign rdata  = rd_hit ? mem_q[fpc_q[IDX_W-1:0]] : 32'd0;

  assign pc_inc = br_pc_i + ADDR_W'(1);
  assign br_tgt = pc_inc + {{(ADDR_W-16){br_imm_i[15]}}, br_imm_i};

  // Jump keeps the region bits of the sequential PC above the 26-bit index.
  generate
    if (ADDR_W > 26) begin : g_jmp_wide
      assign jmp_tgt = {pc_inc[ADDR_W-1:26], jump_idx_i};
    end else begin : g_jmp_narrow
      assign jmp_tgt = jump_idx_i;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (imem_we_i && wr_hit) begin
      mem_q[imem_waddr_i[IDX_W-1:0]] <= imem_wdata_i;
    end
  end

  always_comb begin
    ent_d    = ent_q;
    count_d  = count_q;
    fpc_d    = fpc_q;
    pop      = (count_q != '0) && dec_if.instr_ready;
    redirect = jump_i || (branch_i && zero_i);
    tgt      = jump_i ? jmp_tgt : br_tgt;
    push     = !redirect && ((count_q != QFULL) || pop);
    wr_idx   = count_q - CNT_W'(pop);
    if (redirect) begin
      count_d = '0;
      fpc_d   = tgt;
    end else begin
      // Head lives at slot 0; a pop shifts the remaining entries down.
      if (pop) begin
        for (int i = 0; i < QDEPTH - 1; i++) begin
          ent_d[i] = ent_q[i+1];
        end
      end
      if (push) begin
        for (int i = 0; i < QDEPTH; i++) begin
          if (wr_idx == CNT_W'(i)) begin
            ent_d[i] = {rdata, fpc_q};
          end
        end
        fpc_d = fpc_q + ADDR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      fpc_q   <= RESET_PC;
      for (int i = 0; i < QDEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      fpc_q   <= fpc_d;
      for (int i = 0; i < QDEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

  assign head_valid         = (count_q != '0);
  assign dec_if.instr_valid = head_valid;
  assign dec_if.instr       = head_valid ? ent_q[0].instr : 32'd0;
  assign dec_if.instr_pc    = head_valid ? ent_q[0].pc : '0;
  assign dec_if.pc_plus1    = head_valid ? ent_q[0].pc + ADDR_W'(1) : '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_unit : randomized bench for fetch_unit with queue model     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_we = 1'b0;
  logic [29:0] imem_waddr = '0;
  logic [31:0] imem_wdata = '0;
  logic        branch = 1'b0, zero = 1'b0, jump = 1'b0;
  logic [29:0] br_pc = '0;
  logic [15:0] br_imm = '0;
  logic [25:0] jump_idx = '0;
  logic        low = 1'b0;
  int          passed = 0, failed = 0, total = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(30)) dif ();
  fetch_unit_if #(.ADDR_W(26)) nif ();
  assign nif.instr_ready = 1'b1;

  fetch_unit #(.ADDR_W(30), .DEPTH(32), .QDEPTH(2), .RESET_PC(30'h0)) dut (
    .clk(clk), .rst(rst), .imem_we_i(imem_we), .imem_waddr_i(imem_waddr),
    .imem_wdata_i(imem_wdata), .branch_i(branch), .zero_i(zero), .jump_i(jump),
    .br_pc_i(br_pc), .br_imm_i(br_imm), .jump_idx_i(jump_idx), .dec_if(dif));

  fetch_unit #(.ADDR_W(26), .DEPTH(32), .QDEPTH(1), .RESET_PC(26'h3FFFFFE)) dut_n (
    .clk(clk), .rst(rst), .imem_we_i(imem_we), .imem_waddr_i(imem_waddr[25:0]),
    .imem_wdata_i(imem_wdata), .branch_i(low), .zero_i(low), .jump_i(low),
    .br_pc_i(26'h0), .br_imm_i(16'h0), .jump_idx_i(26'h0), .dec_if(nif));

  // Reference: memory array, FIFO of fetched (pc, data) pairs, fetch PC.
  logic [31:0] mmem [32];
  logic [29:0] mq_pc [$];
  logic [31:0] mq_in [$];
  logic [29:0] mfpc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq_pc.delete();
    mq_in.delete();
    mfpc = '0;
  endtask

  task automatic step();
    logic        pop;
    logic [29:0] pc1;
    int          off;
    if (rst) begin
      model_reset();
    end else begin
      pop = (mq_pc.size() != 0) && dif.instr_ready;
      pc1 = br_pc + 30'd1;
      off = $signed(br_imm);
      if (jump || (branch && zero)) begin
        if (jump) mfpc = (pc1 & 30'h3C000000) | {4'b0, jump_idx};
        else      mfpc = pc1 + 30'(off);
        mq_pc.delete();
        mq_in.delete();
      end else begin
        if (pop) begin
          void'(mq_pc.pop_front());
          void'(mq_in.pop_front());
        end
        if (mq_pc.size() < 2) begin
          mq_pc.push_back(mfpc);
          mq_in.push_back((mfpc < 30'd32) ? mmem[mfpc[4:0]] : 32'd0);
          mfpc = mfpc + 30'd1;
        end
      end
    end
    if (imem_we && imem_waddr < 30'd32) mmem[imem_waddr[4:0]] = imem_wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag);
    logic        v;
    logic [29:0] p;
    v = (mq_pc.size() != 0);
    p = v ? mq_pc[0] : 30'd0;
    chk({tag, "_valid"}, {31'd0, dif.instr_valid}, {31'd0, v});
    chk({tag, "_instr"}, dif.instr, v ? mq_in[0] : 32'd0);
    chk({tag, "_pc"}, {2'b0, dif.instr_pc}, {2'b0, p});
    chk({tag, "_pc1"}, {2'b0, dif.pc_plus1}, v ? {2'b0, p + 30'd1} : 32'd0);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step();
      chk_out(tag);
    end
  endtask

  initial begin
    logic [29:0] n_pc [4];
    dif.instr_ready = 1'b1;
    model_reset();

    // Load memory under reset: words 0..4 random, rest zero, plus an out-of-range write.
    for (int i = 0; i < 32; i++) begin
      imem_we    = 1'b1;
      imem_waddr = 30'(i);
      imem_wdata = (i < 5) ? $urandom : 32'd0;
      step();
    end
    imem_waddr = 30'd40;
    imem_wdata = 32'hDEADBEEF;
    step();
    imem_we = 1'b0;
    chk_out("reset");
    chk("reset_n_valid", {31'd0, nif.instr_valid}, 32'd0);

    rst = 1'b0;
    n_pc[0] = 30'h3FFFFFE; n_pc[1] = 30'h3FFFFFF; n_pc[2] = 30'h0; n_pc[3] = 30'h1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out("seq");
      chk("seq_pc_abs", {2'b0, dif.instr_pc}, 32'(i));
      chk("wrap26_pc", {6'b0, nif.instr_pc}, {2'b0, n_pc[i]});
      chk("wrap26_instr", nif.instr, (i < 2) ? 32'd0 : mmem[i-2]);
    end
    run(38, "seq");

    // Stall from reset release with decode not ready.
    rst = 1'b1;
    step();
    rst = 1'b0;
    dif.instr_ready = 1'b0;
    run(4, "stall");
    chk("stall_head", {2'b0, dif.instr_pc}, 32'd0);
    dif.instr_ready = 1'b1;
    run(1, "drain");
    chk("drain_pc1", {2'b0, dif.instr_pc}, 32'd1);
    run(1, "drain");
    chk("drain_pc2", {2'b0, dif.instr_pc}, 32'd2);
    run(3, "drain");

    // Taken branch back to 1, then untaken branch.
    branch = 1'b1; zero = 1'b1; br_pc = 30'd3; br_imm = 16'hFFFD;
    run(1, "br");
    chk("br_bubble", {31'd0, dif.instr_valid}, 32'd0);
    branch = 1'b0; zero = 1'b0;
    run(1, "br");
    chk("br_target", {2'b0, dif.instr_pc}, 32'd1);
    run(2, "br");
    branch = 1'b1;
    run(3, "br_nt");
    branch = 1'b0;

    // Jump with wrapping upper bits, then jump beating a taken branch.
    jump = 1'b1; br_pc = 30'h3FFFFFFF; jump_idx = 26'h4;
    run(1, "jmp");
    jump = 1'b0;
    run(1, "jmp");
    chk("jmp_target", {2'b0, dif.instr_pc}, 32'd4);
    jump = 1'b1; branch = 1'b1; zero = 1'b1; br_pc = 30'd10; br_imm = 16'd5; jump_idx = 26'd20;
    run(1, "jmp_pri");
    jump = 1'b0; branch = 1'b0; zero = 1'b0;
    run(1, "jmp_pri");
    chk("jmp_pri_target", {2'b0, dif.instr_pc}, 32'd20);

    // Fetch across the end of memory.
    jump = 1'b1; br_pc = 30'd0; jump_idx = 26'd31;
    run(1, "edge");
    jump = 1'b0;
    run(1, "edge");
    chk("edge_pc31", {2'b0, dif.instr_pc}, 32'd31);
    run(1, "edge");
    chk("edge_pc32", {2'b0, dif.instr_pc}, 32'd32);
    chk("edge_instr32", dif.instr, 32'd0);

    // Randomized traffic: ready, redirects and memory writes.
    for (int i = 0; i < 400; i++) begin
      dif.instr_ready = ($urandom % 4) != 0;
      branch     = ($urandom % 12) == 0;
      zero       = $urandom % 2;
      jump       = ($urandom % 16) == 0;
      br_pc      = (($urandom % 8) == 0) ? 30'($urandom) : 30'($urandom % 40);
      br_imm     = 16'($urandom_range(0, 20)) - 16'd10;
      jump_idx   = 26'($urandom % 40);
      imem_we    = ($urandom % 6) == 0;
      imem_waddr = 30'($urandom % 48);
      imem_wdata = $urandom;
      run(1, "rand");
    end
    branch = 1'b0; jump = 1'b0; imem_we = 1'b0; dif.instr_ready = 1'b1;
    run(3, "rand_tail");

    // Reset between clock edges.
    #3;
    rst = 1'b1;
    #1;
    chk("async_valid", {31'd0, dif.instr_valid}, 32'd0);
    chk("async_instr", dif.instr, 32'd0);
    model_reset();
    step();
    rst = 1'b0;
    run(1, "restart");
    chk("restart_pc", {2'b0, dif.instr_pc}, 32'd0);
    run(6, "restart");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
